// File: rtl/bus_ram.sv
// bus_ram: word-organised RAM responder for the CPU single-port memory bus.
// Accepts read/write strobes with byte masks and returns registered read data
// one cycle after the strobe, with a single-cycle rd_valid pulse. Writes to the
// reset-vector words, writes/reads outside the RAM, and simultaneous read and
// write strobes set a sticky error flag.
//
// Optional feature macro: BUS_RAM_MMIO_EN
//   defined   -> 16'hFF00-16'hFFFF is an MMIO page (cycle counter at FF00,
//                LED register at FF04) that never reaches the RAM.
//   undefined -> no MMIO page; leds is tied to zero.
module bus_ram #(
    parameter int    W         = 32,
    parameter int    DEPTH     = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ren,
    input  logic [15:0]  addr,
    output logic [W-1:0] rdata,
    output logic         rd_valid,
    input  logic         wen,
    input  logic [W-1:0] wdata,
    input  logic [3:0]   wmask,
    output logic         err,
    output logic [7:0]   leds
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [14:0] DEPTH_W   = 15'(DEPTH);
    localparam logic [31:0] OOR_DATA  = 32'hDEADBEEF;

    // Storage: one synchronous block RAM, contents untouched by reset.
    logic [W-1:0] mem [DEPTH];

    // Address decode and qualified strobes.
    logic [13:0]   word_idx_s;
    logic [AW-1:0] ram_idx_s;
    logic          in_range_s;
    logic          vector_s;
    logic          mmio_s;
    logic          mmio_bad_s;
    logic          wr_ok_s;
    logic          ram_we_s;
    logic [3:0]    lane_we_s;
    logic [W-1:0]  mmio_rdata_s;
    logic [W-1:0]  rd_mux_s;
    logic          err_set_s;

    logic [W-1:0]  rdata_r;
    logic          rd_valid_r;
    logic          err_r;
    logic [7:0]    leds_r;

    assign word_idx_s = addr[15:2];
    assign ram_idx_s  = word_idx_s[AW-1:0];
    assign in_range_s = ({1'b0, word_idx_s} < DEPTH_W);
    assign vector_s   = (addr < 16'h0008);

`ifdef BUS_RAM_MMIO_EN
    logic [31:0] cycle_cnt_r;
    logic        mmio_cnt_s;
    logic        mmio_led_s;

    assign mmio_s     = (addr[15:8] == 8'hFF);
    assign mmio_cnt_s = mmio_s && (addr[7:2] == 6'd0);
    assign mmio_led_s = mmio_s && (addr[7:2] == 6'd1);

    // Free-running cycle counter; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_r <= 32'h0000_0000;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
        end
    end

    // LED register loaded from the low byte lane when that lane is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds_r <= 8'h00;
        end else if (wr_ok_s && mmio_led_s && wmask[3]) begin
            leds_r <= wdata[7:0];
        end else begin
            leds_r <= leds_r;
        end
    end

    // MMIO read mux and detection of accesses to undecoded MMIO words.
    always_comb begin
        mmio_rdata_s = 32'h0000_0000;
        mmio_bad_s   = 1'b0;
        if (mmio_cnt_s) begin
            mmio_rdata_s = cycle_cnt_r;
        end else if (mmio_led_s) begin
            mmio_rdata_s = {24'h00_0000, leds_r};
        end else begin
            mmio_rdata_s = 32'h0000_0000;
            mmio_bad_s   = mmio_s && (ren || wen);
        end
    end
`else
    assign mmio_s       = 1'b0;
    assign mmio_bad_s   = 1'b0;
    assign mmio_rdata_s = 32'h0000_0000;
    assign leds_r       = 8'h00;
`endif

    // A simultaneous read wins over the write; nothing is written during reset.
    assign wr_ok_s   = wen && !ren && !rst;
    assign ram_we_s  = wr_ok_s && in_range_s && !vector_s && !mmio_s;
    // wmask[3] enables the lowest byte lane, wmask[0] the highest.
    assign lane_we_s = {wmask[0], wmask[1], wmask[2], wmask[3]};

    // Byte-enabled RAM write port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we_s && lane_we_s[i]) begin
                mem[ram_idx_s][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read source selection: MMIO page, RAM, or the out-of-range pattern.
    always_comb begin
        rd_mux_s = OOR_DATA;
        if (mmio_s) begin
            rd_mux_s = mmio_rdata_s;
        end else if (in_range_s) begin
            rd_mux_s = mem[ram_idx_s];
        end else begin
            rd_mux_s = OOR_DATA;
        end
    end

    // Conditions that raise the sticky error flag this cycle.
    always_comb begin
        err_set_s = 1'b0;
        if (rst) begin
            err_set_s = 1'b0;
        end else begin
            err_set_s = (ren && wen)
                     || (ren && !mmio_s && !in_range_s)
                     || (wen && !mmio_s && !in_range_s)
                     || (wen && vector_s)
                     || mmio_bad_s;
        end
    end

    // Registered read data and one-cycle valid pulse; a read during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r    <= 32'h0000_0000;
            rd_valid_r <= 1'b0;
        end else if (ren) begin
            rdata_r    <= rd_mux_s;
            rd_valid_r <= 1'b1;
        end else begin
            rdata_r    <= rdata_r;
            rd_valid_r <= 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign rdata    = rdata_r;
    assign rd_valid = rd_valid_r;
    assign err      = err_r;
    assign leds     = leds_r;

endmodule

// File: tb/tb_bus_ram.sv
// Directed self-checking bench for bus_ram (DEPTH=4096). Inputs are driven
// 1 ns after the rising edge and outputs are sampled at that same point.
// Define BUS_RAM_MMIO_EN for both files to exercise the MMIO page.
module tb_bus_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren;
    logic [15:0] addr;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        err;
    logic [7:0]  leds;

    int errors = 0;
    int checks = 0;

    bus_ram #(.W(32), .DEPTH(4096), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .ren(ren), .addr(addr), .rdata(rdata),
        .rd_valid(rd_valid), .wen(wen), .wdata(wdata), .wmask(wmask),
        .err(err), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; wmask = m; wen = 1'b1;
        tick();
        wen = 1'b0; wmask = 4'b0000;
    endtask

    // Issue one read strobe and check the response in the following cycle.
    task automatic do_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
        addr = a; ren = 1'b1;
        tick();
        ren = 1'b0;
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk({tag, "_data"}, rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

`ifdef BUS_RAM_MMIO_EN
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;
`endif

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = 16'h0000;
        wdata = 32'h0000_0000; wmask = 4'b0000;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_rdata", rdata, 32'h0000_0000);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_leds", {24'd0, leds}, 32'd0);

        // Word write then read, then data hold after the pulse
        do_write(16'h0100, 32'h1122_3344, 4'b1111);
        do_read("word_rd", 16'h0100, 32'h1122_3344);
        tick();
        chk("valid_pulse_once", {31'd0, rd_valid}, 32'd0);
        chk("rdata_hold", rdata, 32'h1122_3344);

        // Byte-lane write: wmask[2] selects bits [15:8]
        do_write(16'h0101, 32'h0000_AB00, 4'b0100);
        do_read("byte_rd", 16'h0100, 32'h1122_AB44);

        // Empty mask writes nothing
        do_write(16'h0100, 32'hFFFF_FFFF, 4'b0000);
        do_read("nomask_rd", 16'h0100, 32'h1122_AB44);

        // Read-after-write in the next cycle, then a back-to-back read
        do_write(16'h0104, 32'hCAFE_F00D, 4'b1111);
        do_read("raw_rd", 16'h0104, 32'hCAFE_F00D);
        do_read("b2b_rd", 16'h0100, 32'h1122_AB44);

        // Other lane mapping: wmask[0] is the top byte
        do_write(16'h0108, 32'h0000_0000, 4'b1111);
        do_write(16'h0108, 32'h7700_0066, 4'b1001);
        do_read("lanes_rd", 16'h0108, 32'h7700_0066);

        // First unprotected word and top in-range word
        do_write(16'h0008, 32'h1234_5678, 4'b1111);
        do_write(16'h3FFC, 32'h0BAD_CAFE, 4'b1111);
        do_write(16'h0200, 32'hA5A5_A5A5, 4'b1111);
        do_read("addr8_rd", 16'h0008, 32'h1234_5678);
        do_read("top_rd", 16'h3FFC, 32'h0BAD_CAFE);
        chk("no_err_yet", {31'd0, err}, 32'd0);

        // Vector protection: write to 0x0004 dropped, err set, neighbour intact
        do_write(16'h0004, 32'hFFFF_FFFF, 4'b1111);
        chk("vec_err", {31'd0, err}, 32'd1);
        do_write(16'h0007, 32'hFFFF_FFFF, 4'b1111);
        do_read("vec_nb_rd", 16'h0008, 32'h1234_5678);

        // Reset clears err; simultaneous strobes serve the read only
        do_reset();
        chk("rst2_err", {31'd0, err}, 32'd0);
        chk("rst2_rdata", rdata, 32'h0000_0000);
        addr = 16'h0200; wdata = 32'h0000_0000; wmask = 4'b1111;
        ren = 1'b1; wen = 1'b1;
        tick();
        ren = 1'b0; wen = 1'b0; wmask = 4'b0000;
        chk("both_valid", {31'd0, rd_valid}, 32'd1);
        chk("both_data", rdata, 32'hA5A5_A5A5);
        chk("both_err", {31'd0, err}, 32'd1);
        do_read("both_nowr_rd", 16'h0200, 32'hA5A5_A5A5);

        // Out of range read just past the end and far away
        do_reset();
        do_read("oor_4000_rd", 16'h4000, 32'hDEAD_BEEF);
        chk("oor_err", {31'd0, err}, 32'd1);
        do_read("oor_8000_rd", 16'h8000, 32'hDEAD_BEEF);

        // Out of range write sets err
        do_reset();
        do_write(16'h4000, 32'h1111_1111, 4'b1111);
        chk("oor_wr_err", {31'd0, err}, 32'd1);

        // Read strobed during reset is discarded; RAM contents survive
        rst = 1'b1; ren = 1'b1; addr = 16'h0100;
        tick();
        chk("rstrd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rstrd_rdata", rdata, 32'h0000_0000);
        rst = 1'b0; ren = 1'b0;
        tick();
        chk("rstrd_valid2", {31'd0, rd_valid}, 32'd0);
        chk("rstrd_err", {31'd0, err}, 32'd0);
        do_read("preserve_rd", 16'h0100, 32'h1122_AB44);

`ifdef BUS_RAM_MMIO_EN
        // LED register write and read-back
        do_write(16'hFF04, 32'h0000_005A, 4'b1000);
        chk("leds_val", {24'd0, leds}, 32'h0000_005A);
        chk("mmio_no_err", {31'd0, err}, 32'd0);
        do_read("leds_rd", 16'hFF04, 32'h0000_005A);
        // Cycle counter: reads three cycles apart differ by three
        addr = 16'hFF00; ren = 1'b1;
        tick();
        ren = 1'b0;
        cnt_a = rdata;
        tick();
        tick();
        addr = 16'hFF00; ren = 1'b1;
        tick();
        ren = 1'b0;
        cnt_b = rdata;
        chk("cnt_valid", {31'd0, rd_valid}, 32'd1);
        chk("cnt_delta", cnt_b - cnt_a, 32'd3);
        // Undecoded MMIO word reads zero and sets err
        do_read("mmio_bad_rd", 16'hFF10, 32'h0000_0000);
        chk("mmio_bad_err", {31'd0, err}, 32'd1);
`else
        // Without MMIO the top page is just out of range
        do_write(16'hFF04, 32'h0000_005A, 4'b1000);
        chk("nommio_leds", {24'd0, leds}, 32'd0);
        chk("nommio_wr_err", {31'd0, err}, 32'd1);
        do_read("nommio_rd", 16'hFF00, 32'hDEAD_BEEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
